// File: rtl/vbsme_pkg.sv
// Shared types, default geometry and width helpers
// for the VBSME full-search motion estimation engine.
package vbsme_pkg;

  localparam int DEF_FRAME_W = 64;
  localparam int DEF_FRAME_H = 64;
  localparam int DEF_BLK_W   = 4;
  localparam int DEF_BLK_H   = 4;
  localparam int DEF_PIX_W   = 8;

  localparam int N      = DEF_BLK_W * DEF_BLK_H;
  localparam int ADDR_W = $clog2(DEF_FRAME_W * DEF_FRAME_H);
  localparam int K_W    = $clog2(N);
  localparam int SAD_W  = DEF_PIX_W + $clog2(N);

  localparam logic [SAD_W-1:0] SAD_INIT = '1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CMP,
    DONE
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int sad_w(input int pix_w, input int n);
    return pix_w + clog2_min1(n);
  endfunction

endpackage

// File: rtl/vbsme_sad_accum.sv
// Registered sum-of-absolute-differences accumulator
// with synchronous clear and enable.
module vbsme_sad_accum #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  output logic [SAD_W-1:0] o_acc
);

  logic signed [PIX_W:0] w_diff;
  logic [PIX_W-1:0]      w_mag;
  logic [SAD_W-1:0]      r_acc;

  assign w_diff = $signed({1'b0, i_a})
                - $signed({1'b0, i_b});

  assign w_mag = w_diff[PIX_W] ? PIX_W'(-w_diff)
                               : w_diff[PIX_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + SAD_W'(w_mag);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/vbsme_search_engine.sv
// Full-search block matcher: scans every window position
// in raster order and keeps the first minimum-SAD hit.
module vbsme_search_engine
  import vbsme_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int BLK_W   = DEF_BLK_W,
  parameter int BLK_H   = DEF_BLK_H,
  parameter int PIX_W   = DEF_PIX_W
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic [clog2_min1(FRAME_W*FRAME_H)-1:0] frame_addr,
  input  logic [PIX_W-1:0] frame_data,
  output logic [clog2_min1(BLK_W*BLK_H)-1:0] window_addr,
  input  logic [PIX_W-1:0] window_data,
  output logic busy,
  output logic complete,
  output logic [clog2_min1(FRAME_W)-1:0] best_x,
  output logic [clog2_min1(FRAME_H)-1:0] best_y,
  output logic [sad_w(PIX_W, BLK_W*BLK_H)-1:0] best_sad
);

  localparam int NP = BLK_W * BLK_H;
  localparam int AW = clog2_min1(FRAME_W * FRAME_H);
  localparam int KW = clog2_min1(NP);
  localparam int XW = clog2_min1(FRAME_W);
  localparam int YW = clog2_min1(FRAME_H);
  localparam int CW = clog2_min1(BLK_W);
  localparam int RW = clog2_min1(BLK_H);
  localparam int SW = sad_w(PIX_W, NP);

  localparam logic [SW-1:0] W_INIT = '1;
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - BLK_W);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - BLK_H);
  localparam logic [KW-1:0] K_LAST = KW'(NP - 1);
  localparam logic [CW-1:0] C_LAST = CW'(BLK_W - 1);

  state_t r_state;
  state_t w_next;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [KW-1:0] r_k;
  logic [CW-1:0] r_kc;
  logic [RW-1:0] r_kr;
  logic [XW-1:0] r_best_x;
  logic [YW-1:0] r_best_y;
  logic [SW-1:0] r_best_sad;

  logic [SW-1:0] w_acc;
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;
  logic w_accept;
  logic w_k_last;
  logic w_x_last;
  logic w_y_last;
  logic w_acc_en;
  logic w_acc_clr;
  logic w_better;

  assign w_accept = (r_state == IDLE) && start;
  assign w_k_last = (r_k == K_LAST);
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);
  assign w_better = (w_acc < r_best_sad);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_k_last) w_next = DRAIN;
      DRAIN:   w_next = CMP;
      CMP:     w_next = (w_x_last && w_y_last)
                        ? DONE : RUN;
      DONE:    if (!start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pixel data lags its address by one cycle,
  // so RUN k=0 has nothing to add yet.
  always_comb begin
    busy      = 1'b0;
    complete  = 1'b0;
    w_acc_en  = 1'b0;
    w_acc_clr = 1'b0;
    unique case (r_state)
      IDLE:  w_acc_clr = start;
      RUN: begin
        busy     = 1'b1;
        w_acc_en = (r_k != '0);
      end
      DRAIN: begin
        busy     = 1'b1;
        w_acc_en = 1'b1;
      end
      CMP: begin
        busy      = 1'b1;
        w_acc_clr = 1'b1;
      end
      DONE:    complete = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x  <= '0;
      r_y  <= '0;
      r_k  <= '0;
      r_kc <= '0;
      r_kr <= '0;
    end else if (w_accept) begin
      r_x  <= '0;
      r_y  <= '0;
      r_k  <= '0;
      r_kc <= '0;
      r_kr <= '0;
    end else if (r_state == RUN) begin
      r_k <= r_k + 1'b1;
      if (r_kc == C_LAST) begin
        r_kc <= '0;
        r_kr <= r_kr + 1'b1;
      end else begin
        r_kc <= r_kc + 1'b1;
      end
    end else if (r_state == CMP) begin
      r_k  <= '0;
      r_kc <= '0;
      r_kr <= '0;
      if (w_x_last) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_best_x   <= '0;
      r_best_y   <= '0;
      r_best_sad <= W_INIT;
    end else if (w_accept) begin
      r_best_sad <= W_INIT;
    end else if ((r_state == CMP) && w_better) begin
      r_best_x   <= r_x;
      r_best_y   <= r_y;
      r_best_sad <= w_acc;
    end
  end

  assign w_row = AW'(r_y) + AW'(r_kr);
  assign w_col = AW'(r_x) + AW'(r_kc);

  assign frame_addr  = (r_state == RUN)
                     ? w_row * AW'(FRAME_W) + w_col
                     : '0;
  assign window_addr = (r_state == RUN) ? r_k : '0;

  assign best_x   = r_best_x;
  assign best_y   = r_best_y;
  assign best_sad = r_best_sad;

  vbsme_sad_accum #(
    .PIX_W (PIX_W),
    .SAD_W (SW)
  ) u_acc (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_clr (w_acc_clr),
    .i_en  (w_acc_en),
    .i_a   (frame_data),
    .i_b   (window_data),
    .o_acc (w_acc)
  );

endmodule
